// File: rtl/load_store_unit.sv
// Data-memory initiator: turns CPU load/store requests into one or two aligned,
// byte-enabled word transactions and sign/zero-extends the reassembled load data.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            SizeCtr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

  state_t                  state_reg, state_next;
  logic                    write_reg;
  logic [2:0]              size_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH-1:0]   lo_reg;
  logic                    err_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;

  logic                    accept;
  logic                    legal_in;
  logic [1:0]              off;
  logic [3:0]              mask;
  logic [7:0]              be8;
  logic [2*DATA_WIDTH-1:0] wd64;
  logic                    split;
  logic [ADDR_WIDTH-1:0]   addr0, addr1;
  logic [DATA_WIDTH-1:0]   lo_src, hi_src, raw, load_result;
  logic [ADDR_WIDTH-1:0]   txn_addr;
  logic [3:0]              txn_be;
  logic [DATA_WIDTH-1:0]   txn_wd;

  function automatic logic size_legal(input logic wr, input logic [2:0] sz);
    case (sz)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return !wr;
      default:                return 1'b0;
    endcase
  endfunction

  assign req_ready = (state_reg == IDLE);
  assign stall     = ~req_ready;
  assign accept    = req_valid && req_ready;
  assign legal_in  = size_legal(req_write, SizeCtr);

  // Lane maths works on the registered request so it stays stable across waits.
  assign off = addr_reg[1:0];
  always_comb begin
    case (size_reg[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end
  assign be8   = {4'b0000, mask} << off;
  assign wd64  = {{DATA_WIDTH{1'b0}}, wdata_reg} << {off, 3'b000};
  assign split = |be8[7:4];
  assign addr0 = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
  assign addr1 = addr0 + ADDR_WIDTH'(4);

  // The final read word is taken straight off the bus so the result can be
  // registered on the same edge that enters DONE.
  assign lo_src = (state_reg == RSP0) ? mem_rdata : lo_reg;
  assign hi_src = (state_reg == RSP1) ? mem_rdata : '0;
  assign raw    = DATA_WIDTH'({hi_src, lo_src} >> {off, 3'b000});

  always_comb begin
    case (size_reg)
      3'b000:  load_result = {{24{raw[7]}}, raw[7:0]};
      3'b100:  load_result = {24'h000000, raw[7:0]};
      3'b001:  load_result = {{16{raw[15]}}, raw[15:0]};
      3'b101:  load_result = {16'h0000, raw[15:0]};
      default: load_result = raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    txn_addr   = '0;
    txn_be     = 4'b0000;
    txn_wd     = '0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = legal_in ? REQ0 : DONE;
      end
      REQ0: begin
        mem_req  = 1'b1;
        mem_we   = write_reg;
        txn_addr = addr0;
        txn_be   = be8[3:0];
        txn_wd   = wd64[DATA_WIDTH-1:0];
        if (mem_gnt) begin
          if (!write_reg) state_next = RSP0;
          else            state_next = split ? REQ1 : DONE;
        end
      end
      RSP0: begin
        if (mem_rvalid) state_next = split ? REQ1 : DONE;
      end
      REQ1: begin
        mem_req  = 1'b1;
        mem_we   = write_reg;
        txn_addr = addr1;
        txn_be   = be8[7:4];
        txn_wd   = wd64[2*DATA_WIDTH-1:DATA_WIDTH];
        if (mem_gnt) state_next = write_reg ? DONE : RSP1;
      end
      RSP1: begin
        if (mem_rvalid) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_reg <= 1'b0;
      size_reg  <= 3'b000;
      addr_reg  <= '0;
      wdata_reg <= '0;
      lo_reg    <= '0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      if (accept) begin
        write_reg <= req_write;
        size_reg  <= SizeCtr;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        err_reg   <= !legal_in;
      end
      if (state_reg == RSP0 && mem_rvalid) lo_reg <= mem_rdata;
      if (accept && !legal_in)
        rdata_reg <= '0;
      else if ((state_reg == RSP0 || state_reg == RSP1) && state_next == DONE)
        rdata_reg <= load_result;
    end
  end

  assign rsp_valid = (state_reg == DONE);
  assign err       = rsp_valid && err_reg;
  assign rsp_rdata = rdata_reg;
  assign mem_addr  = txn_addr;
  assign mem_be    = txn_be;

  // Lanes outside the byte enables are driven to zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign mem_wdata[8*gi +: 8] = txn_be[gi] ? txn_wd[8*gi +: 8] : 8'h00;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a byte-level reference memory predicts
// bus transactions, load results and latency; a word memory answers the DUT.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_write;
  logic [2:0]  SizeCtr;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, stall, rsp_valid, err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem_word [0:255];
  logic [7:0]  ref_byte [0:1023];
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .SizeCtr(SizeCtr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem_word[a[9:2]] = v;
    for (int i = 0; i < 4; i++) ref_byte[{a[9:2], 2'(i)}] = v[8*i +: 8];
  endtask

  function automatic int size_bytes(input logic [2:0] s);
    case (s[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_legal(input bit wr, input logic [2:0] s);
    if (s == 3'd0 || s == 3'd1 || s == 3'd2) return 1'b1;
    if (!wr && (s == 3'd4 || s == 3'd5)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_access(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input int gd, input int rd);
    bit          legal;
    int          n, ntx_exp, exp_lat, k;
    logic [31:0] ew [2];
    logic [3:0]  ebe [2];
    logic [31:0] ewd [2];
    logic [31:0] ld, ba, exp_rdata;
    logic [31:0] ga [4];
    logic [3:0]  gbe [4];
    logic [31:0] gwd [4];
    logic        gwe [4];
    int          ntx, cyc, pulses, wcnt, rcnt, got_lat;
    bit          seen_rsp, in_req, rd_pend, bad_busy, bad_align, unstable, stray_err;
    logic [31:0] rd_a, got_rd;
    logic        got_err;

    // Reference: walk the accessed bytes one by one.
    legal   = is_legal(wr, sz);
    n       = size_bytes(sz);
    ew[0]   = {addr[31:2], 2'b00};
    ew[1]   = ew[0] + 32'd4;
    ebe[0]  = 4'b0; ebe[1] = 4'b0;
    ewd[0]  = 32'b0; ewd[1] = 32'b0;
    ntx_exp = 0;
    ld      = 32'b0;
    if (legal) begin
      ntx_exp = 1;
      for (int i = 0; i < n; i++) begin
        ba = addr + 32'(i);
        k  = ({ba[31:2], 2'b00} == ew[0]) ? 0 : 1;
        if (k == 1) ntx_exp = 2;
        ebe[k][ba[1:0]] = 1'b1;
        ewd[k][8*ba[1:0] +: 8] = wd[8*i +: 8];
        if (wr) ref_byte[ba[9:0]] = wd[8*i +: 8];
        else    ld[8*i +: 8] = ref_byte[ba[9:0]];
      end
      if (!wr) begin
        case (sz)
          3'd0:    last_rdata = {{24{ld[7]}}, ld[7:0]};
          3'd4:    last_rdata = {24'b0, ld[7:0]};
          3'd1:    last_rdata = {{16{ld[15]}}, ld[15:0]};
          3'd5:    last_rdata = {16'b0, ld[15:0]};
          default: last_rdata = ld;
        endcase
      end
      exp_lat = 1 + ntx_exp * (gd + 1 + (wr ? 0 : rd + 1));
    end else begin
      last_rdata = 32'b0;
      exp_lat = 1;
    end
    exp_rdata = last_rdata;

    check_eq("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; SizeCtr = sz; req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; SizeCtr = 3'($urandom);

    cyc = 1; pulses = 0; ntx = 0; wcnt = 0; rcnt = 0; got_lat = 0;
    seen_rsp = 0; in_req = 0; rd_pend = 0; bad_busy = 0; bad_align = 0;
    unstable = 0; stray_err = 0; rd_a = 32'b0; got_rd = 32'b0; got_err = 1'b0;
    while (cyc <= 40) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (rsp_valid) begin
        pulses++;
        if (!seen_rsp) begin got_lat = cyc; got_rd = rsp_rdata; got_err = err; end
        seen_rsp = 1;
      end else if (seen_rsp) begin
        break;
      end
      if (req_ready || stall !== 1'b1) bad_busy = 1;
      if (err && !rsp_valid) stray_err = 1;
      if (mem_req) begin
        if (mem_addr[1:0] != 2'b00) bad_align = 1;
        if (!in_req) begin
          in_req = 1; wcnt = 0;
          if (ntx < 4) begin
            ga[ntx] = mem_addr; gbe[ntx] = mem_be; gwd[ntx] = mem_wdata; gwe[ntx] = mem_we;
          end
          ntx++;
        end else if (ntx <= 4) begin
          if (mem_addr !== ga[ntx-1] || mem_be !== gbe[ntx-1] ||
              mem_wdata !== gwd[ntx-1] || mem_we !== gwe[ntx-1]) unstable = 1;
        end
        if (wcnt == gd) begin
          mem_gnt = 1'b1; in_req = 0;
          if (mem_we) begin
            for (int l = 0; l < 4; l++)
              if (mem_be[l]) mem_word[mem_addr[9:2]][8*l +: 8] = mem_wdata[8*l +: 8];
          end else begin
            rd_pend = 1; rd_a = mem_addr; rcnt = 0;
          end
        end else begin
          wcnt++;
        end
      end else if (rd_pend) begin
        if (rcnt == rd) begin
          mem_rvalid = 1'b1; mem_rdata = mem_word[rd_a[9:2]]; rd_pend = 0;
        end else begin
          rcnt++;
        end
      end
      tick();
      cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;

    check_eq("rsp_seen", {31'b0, seen_rsp}, 32'd1);
    check_eq("rsp_pulses", 32'(pulses), 32'd1);
    check_eq("latency", 32'(got_lat), 32'(exp_lat));
    check_eq("err", {31'b0, got_err}, {31'b0, !legal});
    check_eq("rdata", got_rd, exp_rdata);
    check_eq("ready_after", {31'b0, req_ready}, 32'd1);
    check_eq("busy_stall", {31'b0, bad_busy}, 32'd0);
    check_eq("stray_err", {31'b0, stray_err}, 32'd0);
    check_eq("addr_align", {31'b0, bad_align}, 32'd0);
    check_eq("txn_stable", {31'b0, unstable}, 32'd0);
    check_eq("txn_count", 32'(ntx), 32'(ntx_exp));
    for (int t = 0; t < ntx_exp && t < ntx && t < 2; t++) begin
      check_eq("txn_addr", ga[t], ew[t]);
      check_eq("txn_be", {28'b0, gbe[t]}, {28'b0, ebe[t]});
      check_eq("txn_we", {31'b0, gwe[t]}, {31'b0, wr});
      if (wr) check_eq("txn_wdata", gwd[t], ewd[t]);
    end
    $display("[TB] %s sz=%0d addr=%08h wd=%08h gd=%0d rd=%0d -> lat=%0d txns=%0d err=%0b rdata=%08h",
             wr ? "st" : "ld", sz, addr, wd, gd, rd, got_lat, ntx, got_err, got_rd);
  endtask

  logic [2:0] legal_sizes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; SizeCtr = 3'd0;
    req_addr = 32'b0; req_wdata = 32'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'b0;
    last_rdata = 32'b0;
    for (int w = 0; w < 256; w++) preload({22'b0, 8'(w), 2'b00}, $urandom);

    tick(); tick();
    rst = 1'b0;
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_stall", {31'b0, stall}, 32'd0);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_err", {31'b0, err}, 32'd0);
    check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_be", {28'b0, mem_be}, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);

    // Directed cases
    preload(32'h100, 32'hDEADBEEF);
    do_access(0, 3'd2, 32'h100, $urandom, 0, 0);
    preload(32'h100, 32'h80123456);
    do_access(0, 3'd0, 32'h103, $urandom, 0, 0);
    do_access(0, 3'd4, 32'h103, $urandom, 0, 0);
    do_access(1, 3'd2, 32'h102, 32'h11223344, 0, 0);
    preload(32'h0FC, 32'hAB000000);
    preload(32'h100, 32'h000000CD);
    do_access(0, 3'd1, 32'h0FF, $urandom, 0, 0);
    do_access(0, 3'd5, 32'h0FF, $urandom, 0, 0);
    do_access(1, 3'd2, 32'h200, $urandom, 3, 0);
    do_access(0, 3'd3, 32'h100, $urandom, 0, 0);
    do_access(1, 3'd4, 32'h100, $urandom, 0, 0);
    do_access(0, 3'd2, 32'hFFFFFFFE, $urandom, 1, 1);
    do_access(1, 3'd2, 32'hFFFFFFFD, $urandom, 0, 2);

    // Reset while waiting for read data, then a stale rvalid
    req_valid = 1'b1; req_write = 1'b0; SizeCtr = 3'd2; req_addr = 32'h100;
    tick();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("midrst_ready", {31'b0, req_ready}, 32'd1);
    check_eq("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("midrst_rdata", rsp_rdata, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    check_eq("late_rvalid_rsp", {31'b0, rsp_valid}, 32'd0);
    tick();
    check_eq("late_rvalid_rsp2", {31'b0, rsp_valid}, 32'd0);
    check_eq("late_rvalid_rdata", rsp_rdata, 32'd0);
    last_rdata = 32'b0;

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      bit          wr;
      logic [2:0]  sz;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) sz = 3'($urandom_range(0, 7));
      else                           sz = legal_sizes[$urandom_range(0, 4)];
      if ($urandom_range(0, 15) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else                            a = 32'h100 + 32'($urandom_range(0, 127));
      do_access(wr, sz, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
